// File: rtl/fractal_job_arbiter.sv
// Round-robin arbiter sharing one fractal_kernel among NUM_REQ requesters, with tagged responses.
// Define FRACTAL_ARB_WATCHDOG_EN to add the hung-kernel watchdog (FLUSH state, error responses).
module fractal_job_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*256-1:0]   req_pixel,
  input  logic [NUM_REQ*32-1:0]    req_config,
  output logic [255:0]             krn_pixel_block,
  output logic [31:0]              krn_config,
  output logic                     krn_srst_n,
  input  logic [127:0]             krn_coeff,
  input  logic                     krn_valid,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [127:0]             rsp_coeff,
  output logic                     rsp_error
);

  localparam int unsigned PIX_W   = 256;
  localparam int unsigned CFG_W   = 32;
  localparam int unsigned COEFF_W = 128;
  localparam int unsigned SUM_W   = ID_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    grant_off;
  logic [ID_W-1:0]    job_id;
  logic [NUM_REQ-1:0] req_rot;
  logic [SUM_W-1:0]   grant_sum;
  logic               grant_any;
  logic               grant_fire;
  logic               armed;
  logic               done_c;
  logic [PIX_W-1:0]   pix_q;
  logic [CFG_W-1:0]   cfg_q;
  logic [COEFF_W-1:0] coeff_q;
  logic               rsp_valid_q;

`ifdef FRACTAL_ARB_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;
  logic            flush_cnt;
  logic            srst_n_q;
  logic            rsp_error_q;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
  assign krn_srst_n = srst_n_q;
  assign rsp_error  = rsp_error_q;
`else
  assign krn_srst_n = 1'b1;
  assign rsp_error  = 1'b0;
`endif

  // Rotate requests so rr_ptr lands on bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    req_rot   = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    grant_off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) grant_off = ID_W'(j);
    end
    grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
    if (grant_sum >= SUM_W'(NUM_REQ)) grant_idx = ID_W'(grant_sum - SUM_W'(NUM_REQ));
    else                              grant_idx = grant_sum[ID_W-1:0];
    grant_any = |req_valid;
  end

  assign done_c = armed && krn_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_any) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (done_c) state_nxt = ST_RESP;
`ifdef FRACTAL_ARB_WATCHDOG_EN
        else if (wd_expired) state_nxt = ST_FLUSH;
`endif
      end
`ifdef FRACTAL_ARB_WATCHDOG_EN
      ST_FLUSH: if (flush_cnt) state_nxt = ST_RESP;
`else
      ST_FLUSH: state_nxt = ST_IDLE;
`endif
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant strobe is combinational and masked while reset is held.
  always_comb begin
    grant_fire = 1'b0;
    req_ready  = '0;
    if (state == ST_IDLE && grant_any && rst_n) begin
      grant_fire = 1'b1;
      req_ready  = NUM_REQ'(1) << grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      job_id      <= '0;
      pix_q       <= '0;
      cfg_q       <= '0;
      coeff_q     <= '0;
      armed       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (grant_fire) begin
        pix_q  <= PIX_W'(req_pixel >> (32'(grant_idx) * PIX_W));
        cfg_q  <= CFG_W'(req_config >> (32'(grant_idx) * CFG_W));
        job_id <= grant_idx;
        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        armed  <= 1'b0;
      end
      // A valid still held from the previous job must drop before we trust it.
      if (state == ST_WAIT) begin
        if (!krn_valid) armed <= 1'b1;
        if (done_c) coeff_q <= krn_coeff;
      end
`ifdef FRACTAL_ARB_WATCHDOG_EN
      if (state == ST_FLUSH && flush_cnt) coeff_q <= '0;
`endif
      rsp_valid_q <= (state_nxt == ST_RESP);
    end
  end

`ifdef FRACTAL_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      flush_cnt   <= 1'b0;
      srst_n_q    <= 1'b1;
      rsp_error_q <= 1'b0;
    end else begin
      if (grant_fire) wd_cnt <= '0;
      else if (state == ST_WAIT && wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
      if (state == ST_WAIT && done_c) rsp_error_q <= 1'b0;
      if (state == ST_FLUSH) begin
        flush_cnt <= ~flush_cnt;
        if (flush_cnt) rsp_error_q <= 1'b1;
      end
      srst_n_q <= (state_nxt != ST_FLUSH);
    end
  end
`endif

  assign krn_pixel_block = pix_q;
  assign krn_config      = cfg_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = job_id;
  assign rsp_coeff       = coeff_q;

endmodule

// File: tb/tb_fractal_job_arbiter.sv
// Self-checking bench for fractal_job_arbiter: kernel model plus response scoreboard.
module tb_fractal_job_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    int           id;
    logic [127:0] coeff;
    logic         err;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*256-1:0] req_pixel;
  logic [NUM_REQ*32-1:0]  req_config;
  logic [255:0]           krn_pixel_block;
  logic [31:0]            krn_config;
  logic                   krn_srst_n;
  logic [127:0]           krn_coeff;
  logic                   krn_valid;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [127:0]           rsp_coeff;
  logic                   rsp_error;

  fractal_job_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pixel(req_pixel), .req_config(req_config),
    .krn_pixel_block(krn_pixel_block), .krn_config(krn_config), .krn_srst_n(krn_srst_n),
    .krn_coeff(krn_coeff), .krn_valid(krn_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_coeff(rsp_coeff), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];
  exp_t         mon_e;
  int           exp_ptr = 0;
  logic [255:0] pix_tb [NUM_REQ];
  logic [31:0]  cfg_tb [NUM_REQ];

  // Kernel model: kc counts cycles since grant; stale valid for kc<=k_stale, result from kc>=k_done.
  int           k_stale = 0;
  int           k_done  = 2;
  bit           k_never = 1'b0;
  bit           k_fn    = 1'b1;
  logic [127:0] k_coeff = '0;
  int           kc      = 0;
  bit           kbusy   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbusy <= 1'b0;
      kc    <= 0;
    end else if (!krn_srst_n) begin
      kbusy <= 1'b0;
      kc    <= 0;
    end else if (|req_ready) begin
      kbusy <= 1'b1;
      kc    <= 1;
    end else if (kbusy && kc < 100000) begin
      kc <= kc + 1;
    end
  end

  always_comb begin
    krn_valid = 1'b0;
    krn_coeff = '0;
    if (kbusy) begin
      if (kc <= k_stale) begin
        krn_valid = 1'b1;
        krn_coeff = 128'hBAD0_BAD0;
      end else if (!k_never && kc >= k_done) begin
        krn_valid = 1'b1;
        krn_coeff = k_fn ? {krn_pixel_block[95:0], krn_config} : k_coeff;
      end
    end
  end

  // Response scoreboard and grant one-hot monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != '0) begin
        checks++;
        if ($countones(req_ready) != 1) begin
          errors++;
          $display("FAIL req_ready_onehot got %b want one-hot", req_ready);
        end
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got id=%0d coeff=%h err=%b want no response", rsp_id, rsp_coeff, rsp_error);
        end else begin
          mon_e = sb.pop_front();
          if (rsp_id !== ID_W'(mon_e.id) || rsp_coeff !== mon_e.coeff || rsp_error !== mon_e.err) begin
            errors++;
            $display("FAIL rsp_data got id=%0d coeff=%h err=%b want id=%0d coeff=%h err=%b",
                     rsp_id, rsp_coeff, rsp_error, mon_e.id, mon_e.coeff, mon_e.err);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [255:0] p, input logic [31:0] c);
    req_pixel[i*256 +: 256] = p;
    req_config[i*32 +: 32]  = c;
    pix_tb[i] = p;
    cfg_tb[i] = c;
  endtask

  task automatic push_exp(input int id, input logic [127:0] c, input logic e);
    exp_t t;
    t.id = id;
    t.coeff = c;
    t.err = e;
    sb.push_back(t);
  endtask

  function automatic int exp_grant();
    int idx;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (exp_ptr + k) % NUM_REQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic wait_grant(output int g, output bit ok);
    g = -1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
        break;
      end
    end
  endtask

  task automatic wait_rsp(input int n0, output int n, output bit ok);
    n = n0;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ptr = 0;
  endtask

  task automatic test_reset();
    req_valid = '1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got ready=%b rsp_valid=%b want 0000/0", req_ready, rsp_valid);
    end
    checks++;
    if (rsp_id !== '0 || rsp_coeff !== '0 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp got id=%0d coeff=%h err=%b want 0/0/0", rsp_id, rsp_coeff, rsp_error);
    end
    checks++;
    if (krn_pixel_block !== '0 || krn_config !== '0 || krn_srst_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_krn got cfg=%h srst_n=%b want 0/1", krn_config, krn_srst_n);
    end
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    int g;
    int n;
    bit ok;
    k_fn = 1'b0; k_stale = 0; k_done = 5; k_never = 1'b0; k_coeff = 128'hDEAD_BEEF;
    set_req(2, {32{8'hA5}}, 32'h0108_1004);
    req_valid = 4'b0100;
    wait_grant(g, ok);
    checks++;
    if (!ok || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant got %b want 0100", req_ready);
    end
    checks++;
    if (krn_pixel_block !== '0) begin
      errors++;
      $display("FAIL single_pix_early got %h want 0", krn_pixel_block);
    end
    push_exp(2, 128'hDEAD_BEEF, 1'b0);
    exp_ptr = 3;
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (krn_pixel_block !== {32{8'hA5}} || krn_config !== 32'h0108_1004) begin
      errors++;
      $display("FAIL single_krn got cfg=%h pix=%h want 01081004/a5..", krn_config, krn_pixel_block);
    end
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL single_ready_wait got %b want 0000", req_ready);
    end
    wait_rsp(1, n, ok);
    checks++;
    if (!ok || n != 6) begin
      errors++;
      $display("FAIL single_latency got cycle %0d (seen=%0d) want 6", n, ok);
    end
    tick();
  endtask

  task automatic test_round_robin();
    int g;
    int prev;
    int n;
    bit ok;
    apply_reset();
    k_fn = 1'b1; k_stale = 0; k_done = 2; k_never = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, {8{32'hC0DE_0000 + 32'(i)}}, 32'h0100_0000 + 32'(i) * 32'h1111);
    req_valid = '1;
    prev = -1;
    for (int j = 0; j < 8; j++) begin
      wait_grant(g, ok);
      checks++;
      if (!ok || g != j % NUM_REQ || g == prev) begin
        errors++;
        $display("FAIL rr_order job %0d got %0d want %0d", j, g, j % NUM_REQ);
      end
      if (ok) begin
        push_exp(g, {pix_tb[g][95:0], cfg_tb[g]}, 1'b0);
        exp_ptr = (g + 1) % NUM_REQ;
      end
      prev = g;
      tick();
    end
    req_valid = '0;
    wait_rsp(0, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_last_rsp got none want response");
    end
    tick();
  endtask

  task automatic test_stale();
    int g;
    int n;
    bit ok;
    k_fn = 1'b0; k_stale = 3; k_done = 5; k_never = 1'b0; k_coeff = 128'h1234;
    req_valid = 4'b0010;
    wait_grant(g, ok);
    checks++;
    if (!ok || g != 1) begin
      errors++;
      $display("FAIL stale_grant got %0d want 1", g);
    end
    push_exp(1, 128'h1234, 1'b0);
    exp_ptr = 2;
    tick();
    req_valid = '0;
    wait_rsp(0, n, ok);
    checks++;
    if (!ok || n != 6) begin
      errors++;
      $display("FAIL stale_latency got cycle %0d want 6", n);
    end
    tick();
    k_stale = 0;
  endtask

  task automatic test_backpressure();
    int g;
    int g2;
    int n;
    bit ok;
    logic [127:0] ec;
    k_fn = 1'b1; k_stale = 0; k_done = 2; k_never = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '1;
    wait_grant(g, ok);
    checks++;
    if (!ok || g != exp_grant()) begin
      errors++;
      $display("FAIL bp_grant got %0d want %0d", g, exp_grant());
    end
    if (g < 0) g = 0;
    ec = {pix_tb[g][95:0], cfg_tb[g]};
    push_exp(g, ec, 1'b0);
    exp_ptr = (g + 1) % NUM_REQ;
    tick();
    wait_rsp(0, n, ok);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== '0 || rsp_id !== ID_W'(g) || rsp_coeff !== ec || rsp_error !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got v=%b rdy=%b id=%0d coeff=%h want 1/0000/%0d/%h",
                 i, rsp_valid, req_ready, rsp_id, rsp_coeff, g, ec);
      end
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL bp_handshake_ready got %b want 0000", req_ready);
    end
    @(negedge clk);
    g2 = exp_grant();
    checks++;
    if (req_ready !== NUM_REQ'(1) << g2) begin
      errors++;
      $display("FAIL bp_next_grant got %b want req %0d", req_ready, g2);
    end
    push_exp(g2, {pix_tb[g2][95:0], cfg_tb[g2]}, 1'b0);
    exp_ptr = (g2 + 1) % NUM_REQ;
    tick();
    req_valid = '0;
    wait_rsp(0, n, ok);
    tick();
  endtask

  task automatic test_watchdog();
    int g;
    bit ok;
    int low_n;
    int first_low;
    bit seen;
    k_never = 1'b1; k_stale = 0;
    req_valid = 4'b0010;
    wait_grant(g, ok);
    checks++;
    if (!ok || g != 1) begin
      errors++;
      $display("FAIL wd_grant got %0d want 1", g);
    end
    exp_ptr = 2;
`ifdef FRACTAL_ARB_WATCHDOG_EN
    push_exp(1, '0, 1'b1);
`endif
    tick();
    req_valid = '0;
    low_n = 0;
    first_low = -1;
    seen = 1'b0;
`ifdef FRACTAL_ARB_WATCHDOG_EN
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (!krn_srst_n) begin
        low_n++;
        if (first_low < 0) first_low = n;
      end
      if (rsp_valid) begin
        seen = 1'b1;
        checks++;
        if (n != int'(TIMEOUT) + 3) begin
          errors++;
          $display("FAIL wd_latency got cycle %0d want %0d", n, TIMEOUT + 3);
        end
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wd_no_rsp got none want error response");
    end
    checks++;
    if (low_n != 2 || first_low != int'(TIMEOUT) + 1) begin
      errors++;
      $display("FAIL wd_srst got %0d low cycles from %0d want 2 from %0d", low_n, first_low, TIMEOUT + 1);
    end
    tick();
`else
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
      if (!krn_srst_n) low_n++;
    end
    checks++;
    if (seen || low_n != 0) begin
      errors++;
      $display("FAIL wd_disabled got rsp=%0d srst_low=%0d want 0/0", seen, low_n);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    int g;
    int n;
    bit ok;
`ifdef FRACTAL_ARB_WATCHDOG_EN
    k_never = 1'b1;
    req_valid = 4'b0010;
    wait_grant(g, ok);
    checks++;
    if (!ok || g != 1) begin
      errors++;
      $display("FAIL rmw_grant got %0d want 1", g);
    end
    exp_ptr = 2;
    tick();
`endif
    req_valid = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmw_busy got ready=%b v=%b want 0000/0", req_ready, rsp_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_coeff !== '0 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL rmw_rsp_reset got rdy=%b v=%b id=%0d err=%b want 0", req_ready, rsp_valid, rsp_id, rsp_error);
    end
    checks++;
    if (krn_pixel_block !== '0 || krn_config !== '0 || krn_srst_n !== 1'b1) begin
      errors++;
      $display("FAIL rmw_krn_reset got cfg=%h srst_n=%b want 0/1", krn_config, krn_srst_n);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ptr = 0;
    k_never = 1'b0; k_fn = 1'b1; k_done = 2;
    wait_grant(g, ok);
    checks++;
    if (!ok || g != 0) begin
      errors++;
      $display("FAIL rmw_first_grant got %0d want 0", g);
    end
    if (ok && g >= 0) begin
      push_exp(g, {pix_tb[g][95:0], cfg_tb[g]}, 1'b0);
      exp_ptr = (g + 1) % NUM_REQ;
    end
    tick();
    req_valid = '0;
    wait_rsp(0, n, ok);
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    rsp_ready  = 1'b1;
    req_pixel  = '0;
    req_config = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pix_tb[i] = '0;
      cfg_tb[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_stale();
    test_backpressure();
    test_watchdog();
    test_reset_mid_wait();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fractal_job_arbiter.md
# fractal_job_arbiter

Shares a single `fractal_kernel` instance among `NUM_REQ` independent requesters (encoder tiles / host queues). It round-robin arbitrates pixel-block jobs, holds the chosen job's pixel block and config stable on the kernel inputs, and waits for the kernel result. It then returns the coefficients tagged with the requester ID over a valid/ready response port. An optional watchdog soft-resets a hung kernel and reports an error response.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default 3: width of `rsp_id`; must satisfy 2^ID_W >= NUM_REQ.
- `TIMEOUT`, default 1024: kernel cycles allowed per job before a watchdog abort.
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, NUM_REQ: per-requester job request.
- `req_ready`, out, NUM_REQ: one-hot accept strobe; at most one bit set per cycle.
- `req_pixel`, in, NUM_REQ*256: pixel block per requester; slice i is bits [i*256 +: 256].
- `req_config`, in, NUM_REQ*32: config word per requester; slice i is bits [i*32 +: 32].
- `krn_pixel_block`, out, 256: to kernel `pixel_block`.
- `krn_config`, out, 32: to kernel `config_reg`.
- `krn_srst_n`, out, 1: active-low soft reset to the kernel, ANDed with `rst_n` at the kernel.
- `krn_coeff`, in, 128: from kernel `fractal_coeff`.
- `krn_valid`, in, 1: from kernel `valid_out`.
- `rsp_valid`, out, 1: response available.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_id`, out, ID_W: index of the requester that owns the response.
- `rsp_coeff`, out, 128: result coefficients.
- `rsp_error`, out, 1: the job was aborted by the watchdog; `rsp_coeff` is 0.

## Operation
- FSM states: IDLE, WAIT, FLUSH, RESP. Reset state is IDLE.
- IDLE:
  - When any `req_valid` bit is set, grant g = the first set bit searching upward from `rr_ptr`, wrapping.
  - `req_ready[g]` = 1 combinationally in this cycle.
  - Capture `req_pixel[g]`, `req_config[g]` and g.
  - Set `rr_ptr` = (g+1) mod NUM_REQ.
  - Clear `armed`, clear `wd_cnt`, go to WAIT.
- `krn_pixel_block`/`krn_config` always drive the captured registers, which change only on a grant.
- WAIT, arming:
  - The kernel may still hold `valid_out` from the previous job.
  - `armed` is set on the first cycle `krn_valid` = 0.
  - `krn_valid` is ignored while `armed` = 0.
- WAIT, completion: when `armed` && `krn_valid`, latch `krn_coeff` into `rsp_coeff`, set `rsp_error` = 0 and go to RESP.
- WAIT, watchdog: `wd_cnt` increments each WAIT cycle, saturating. On reaching TIMEOUT-1 without completion, go to FLUSH.
- FLUSH:
  - `krn_srst_n` = 0 for exactly 2 cycles.
  - Then set `rsp_coeff` = 0, `rsp_error` = 1 and go to RESP.
- RESP:
  - `rsp_valid` = 1; `rsp_id`/`rsp_coeff`/`rsp_error` are held stable.
  - On `rsp_valid && rsp_ready`, go to IDLE.
  - No new grant is made in the handshake cycle.
- A requester must hold `req_valid`/data until its `req_ready`. Deasserting early is legal: the request is simply not granted.
- Only one job is in flight; `req_ready` is all-zero outside IDLE.
- `rr_ptr` wraps from NUM_REQ-1 to 0. With a single active requester, it is granted every job.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_coeff` = 0, `rsp_error` = 0.
  - `krn_pixel_block` = 0, `krn_config` = 0, `krn_srst_n` = 1.
  - `rr_ptr` = 0, `armed` = 0, `wd_cnt` = 0.
- Grant-to-kernel latency: captured data appears on `krn_*` the cycle after `req_ready`.
- Completion-to-response latency: `rsp_valid` rises 1 cycle after the qualifying `krn_valid` edge.
- Timeout abort: `rsp_valid` rises TIMEOUT+2 cycles after entering WAIT (TIMEOUT WAIT cycles plus 2 FLUSH cycles).
- Minimum job spacing: grant, then at least 2 WAIT cycles (arm, valid), then RESP ≥1 cycle. The next grant is the cycle after the RESP handshake.
- Reset asserted mid-job aborts asynchronously to IDLE; no response is produced for the lost job.
- `krn_valid` is high in the same cycle as a watchdog expiry: completion wins and no FLUSH occurs.

## Configuration
- Macro: `FRACTAL_ARB_WATCHDOG_EN`.
- Defined: watchdog, FLUSH state and `wd_cnt` are present, as described above.
- Undefined:
  - WAIT has no timeout; FLUSH is never entered.
  - `krn_srst_n` is tied to 1 and `rsp_error` is tied to 0.
  - `TIMEOUT` is ignored; `wd_cnt` is not synthesized.

## Test plan
- Single request: `req_valid` = 4'b0100, pixel = 256'hA5…, config = 32'h0108_1004; kernel model returns 128'hDEAD_BEEF after 5 cycles. Expect `req_ready` = 4'b0100 for one cycle, `krn_pixel_block` = 256'hA5… the next cycle, then `rsp_valid` = 1, `rsp_id` = 2, `rsp_coeff` = 128'hDEAD_BEEF, `rsp_error` = 0.
- Round robin: all four requesters held valid for 8 jobs with `rsp_ready` = 1. Expect grant order 0, 1, 2, 3, 0, 1, 2, 3, with no requester granted twice in a row.
- Stale valid: kernel model holds `krn_valid` = 1 for 3 cycles after the grant, then 0, then 1 with 128'h1234. Expect only 128'h1234 returned; the stale result is never reported.
- Backpressure: `rsp_ready` = 0 for 10 cycles during RESP. Expect outputs stable and `req_ready` = 0 throughout; the next grant comes the cycle after `rsp_ready` = 1.
- Watchdog (macro defined, TIMEOUT = 16): kernel never asserts valid. Expect `krn_srst_n` low for 2 cycles after 16 WAIT cycles, then `rsp_error` = 1, `rsp_coeff` = 0. Same stimulus with macro undefined: no response after 1000 cycles.
- Reset mid-WAIT: pulse `rst_n` low. Expect all outputs at reset values immediately, `rr_ptr` = 0, and the next grant going to requester 0 when all are valid.
